// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: three data channels plus a constant clock-channel pattern.
// Optional macro DVI_OUTPUT_REG_EN adds one register stage on all four outputs.

module dvi_tmds_channel (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       c0,
    input  logic       c1,
    input  logic       de,
    output logic [9:0] symbol
);
    localparam logic [9:0] CTL_00 = 10'h354;
    localparam logic [9:0] CTL_01 = 10'h0AB;
    localparam logic [9:0] CTL_10 = 10'h154;
    localparam logic [9:0] CTL_11 = 10'h2AB;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    logic [7:0]        d_r;
    logic              de_r;
    logic [1:0]        c_r;
    logic [3:0]        n1d_s;
    logic              xnor_s;
    logic [8:0]        qm_s;
    logic [3:0]        n1q_s;
    logic [3:0]        n0q_s;
    logic signed [4:0] diff_s;
    logic signed [4:0] qm2_s;
    logic signed [4:0] nqm2_s;
    logic signed [4:0] cnt_r;
    logic signed [4:0] cnt_nxt_s;
    logic [9:0]        sym_s;
    logic [9:0]        sym_r;

    // Stage 1: capture pixel, enable and control bits
    always_ff @(posedge clk) begin
        if (reset) begin
            d_r  <= 8'd0;
            de_r <= 1'b0;
            c_r  <= 2'b00;
        end else begin
            d_r  <= data;
            de_r <= de;
            c_r  <= {c1, c0};
        end
    end

    // Transition minimisation of the registered byte
    always_comb begin
        n1d_s   = ones8(d_r);
        xnor_s  = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && (d_r[0] == 1'b0));
        qm_s    = 9'd0;
        qm_s[0] = d_r[0];
        for (int i = 1; i < 8; i++) begin
            if (xnor_s) begin
                qm_s[i] = ~(qm_s[i-1] ^ d_r[i]);
            end else begin
                qm_s[i] = qm_s[i-1] ^ d_r[i];
            end
        end
        qm_s[8] = ~xnor_s;
    end

    // DC balancing and control token selection
    always_comb begin
        n1q_s     = ones8(qm_s[7:0]);
        n0q_s     = 4'd8 - n1q_s;
        diff_s    = $signed({1'b0, n1q_s}) - $signed({1'b0, n0q_s});
        qm2_s     = qm_s[8] ? 5'sd2 : 5'sd0;
        nqm2_s    = qm_s[8] ? 5'sd0 : 5'sd2;
        sym_s     = CTL_00;
        cnt_nxt_s = 5'sd0;
        if (!de_r) begin
            case (c_r)
                2'b00:   sym_s = CTL_00;
                2'b01:   sym_s = CTL_01;
                2'b10:   sym_s = CTL_10;
                2'b11:   sym_s = CTL_11;
                default: sym_s = CTL_00;
            endcase
            cnt_nxt_s = 5'sd0;
        end else if ((cnt_r == 5'sd0) || (n1q_s == n0q_s)) begin
            sym_s = {~qm_s[8], qm_s[8], (qm_s[8] ? qm_s[7:0] : ~qm_s[7:0])};
            if (qm_s[8]) begin
                cnt_nxt_s = cnt_r + diff_s;
            end else begin
                cnt_nxt_s = cnt_r - diff_s;
            end
        end else if (((cnt_r > 5'sd0) && (n1q_s > n0q_s)) ||
                     ((cnt_r < 5'sd0) && (n0q_s > n1q_s))) begin
            sym_s     = {1'b1, qm_s[8], ~qm_s[7:0]};
            cnt_nxt_s = cnt_r + qm2_s - diff_s;
        end else begin
            sym_s     = {1'b0, qm_s[8], qm_s[7:0]};
            cnt_nxt_s = cnt_r + diff_s - nqm2_s;
        end
    end

    // Stage 2: symbol and running disparity
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_r <= CTL_00;
            cnt_r <= 5'sd0;
        end else begin
            sym_r <= sym_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    assign symbol = sym_r;

endmodule

module dvi_tmds_encoder (
    input  logic       clkx1in,
    input  logic       reset,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       vde,
    output logic [9:0] tmds_blue,
    output logic [9:0] tmds_green,
    output logic [9:0] tmds_red,
    output logic [9:0] tmds_clk
);
    localparam logic [9:0] CLK_PATTERN = 10'h3E0;

    logic [9:0] blue_s;
    logic [9:0] green_s;
    logic [9:0] red_s;

    dvi_tmds_channel u_blue (
        .clk    (clkx1in),
        .reset  (reset),
        .data   (blue_in),
        .c0     (hsync),
        .c1     (vsync),
        .de     (vde),
        .symbol (blue_s)
    );

    dvi_tmds_channel u_green (
        .clk    (clkx1in),
        .reset  (reset),
        .data   (green_in),
        .c0     (1'b0),
        .c1     (1'b0),
        .de     (vde),
        .symbol (green_s)
    );

    dvi_tmds_channel u_red (
        .clk    (clkx1in),
        .reset  (reset),
        .data   (red_in),
        .c0     (1'b0),
        .c1     (1'b0),
        .de     (vde),
        .symbol (red_s)
    );

`ifdef DVI_OUTPUT_REG_EN
    logic [9:0] blue_r;
    logic [9:0] green_r;
    logic [9:0] red_r;
    logic [9:0] clk_r;

    // Extra retiming stage towards the serializers
    always_ff @(posedge clkx1in) begin
        if (reset) begin
            blue_r  <= 10'h354;
            green_r <= 10'h354;
            red_r   <= 10'h354;
            clk_r   <= CLK_PATTERN;
        end else begin
            blue_r  <= blue_s;
            green_r <= green_s;
            red_r   <= red_s;
            clk_r   <= CLK_PATTERN;
        end
    end

    assign tmds_blue  = blue_r;
    assign tmds_green = green_r;
    assign tmds_red   = red_r;
    assign tmds_clk   = clk_r;
`else
    assign tmds_blue  = blue_s;
    assign tmds_green = green_s;
    assign tmds_red   = red_s;
    assign tmds_clk   = CLK_PATTERN;
`endif

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed-vector and randomized decode/balance bench for dvi_tmds_encoder.
module tb_dvi_tmds_encoder;
`ifdef DVI_OUTPUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int NR = 400;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] red_in, green_in, blue_in;
    logic       hsync, vsync, vde;
    logic [9:0] tmds_blue, tmds_green, tmds_red, tmds_clk;

    int total = 0;
    int bad = 0;
    int rs[3];

    typedef struct {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [9:0] eb;
        logic [9:0] eg;
        logic [9:0] er;
    } vec_t;

    vec_t tbl[$];

    logic       h_de[NR];
    logic       h_hs[NR];
    logic       h_vs[NR];
    logic [7:0] h_r[NR];
    logic [7:0] h_g[NR];
    logic [7:0] h_b[NR];

    dvi_tmds_encoder dut (
        .clkx1in    (clk),
        .reset      (reset),
        .red_in     (red_in),
        .green_in   (green_in),
        .blue_in    (blue_in),
        .hsync      (hsync),
        .vsync      (vsync),
        .vde        (vde),
        .tmds_blue  (tmds_blue),
        .tmds_green (tmds_green),
        .tmds_red   (tmds_red),
        .tmds_clk   (tmds_clk)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic de, input logic hs, input logic vs,
                                input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                input logic [9:0] eb, input logic [9:0] eg, input logic [9:0] er);
        vec_t v;
        v.de = de; v.hs = hs; v.vs = vs;
        v.r = r; v.g = g; v.b = b;
        v.eb = eb; v.eg = eg; v.er = er;
        return v;
    endfunction

    function automatic logic [9:0] token(input logic c1, input logic c0);
        logic [1:0] c;
        c = {c1, c0};
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    // Reference TMDS data-symbol decoder
    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    function automatic int disparity(input logic [9:0] s);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) n += int'(s[i]);
        return 2 * n - 10;
    endfunction

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        vde = de; hsync = hs; vsync = vs;
        red_in = r; green_in = g; blue_in = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_rand(input int ch, input logic [9:0] sym, input logic de,
                              input logic c1, input logic c0, input logic [7:0] d);
        if (!de) begin
            rs[ch] = 0;
            chk($sformatf("rand_token_ch%0d", ch), sym, token(c1, c0));
        end else begin
            chk($sformatf("rand_decode_ch%0d", ch), {2'b00, decode(sym)}, {2'b00, d});
            rs[ch] += disparity(sym);
            total++;
            if (rs[ch] > 10 || rs[ch] < -10) begin
                bad++;
                $display("FAIL rand_balance_ch%0d: got %0d want |x|<=10", ch, rs[ch]);
            end
        end
    endtask

    initial begin
        // Directed stream; cnt history per channel noted as b/g/r
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 10'h0AB, 10'h354, 10'h354));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 10'h154, 10'h354, 10'h354));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 10'h2AB, 10'h354, 10'h354));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 10'h100, 10'h200, 10'h100)); // -8/-8/-8
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 10'h3FF, 10'h0FF, 10'h3FF)); // 2/-2/2
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 10'h100, 10'h0FF, 10'h100)); // -6/4/-6
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, 10'h200, 10'h100, 10'h200)); // -8/-8/-8
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h55, 10'h133, 10'h3FF, 10'h0FF)); // -8/2/-2
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h55, 10'h133, 10'h100, 10'h0FF)); // -8/-6/4
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h0F, 10'h3FA, 10'h3FF, 10'h200)); // -2/4/-4
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 10'h2AB, 10'h354, 10'h354));

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step;
        step;
        chk("reset_blue", tmds_blue, 10'h354);
        chk("reset_green", tmds_green, 10'h354);
        chk("reset_red", tmds_red, 10'h354);
        chk("reset_clk", tmds_clk, 10'h3E0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size() + LAT - 1; i++) begin
            int j;
            if (i < tbl.size()) drive(tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].r, tbl[i].g, tbl[i].b);
            else drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            step;
            j = i - (LAT - 1);
            if (j >= 0) begin
                chk($sformatf("vec%0d_blue", j), tmds_blue, tbl[j].eb);
                chk($sformatf("vec%0d_green", j), tmds_green, tbl[j].eg);
                chk($sformatf("vec%0d_red", j), tmds_red, tbl[j].er);
                chk($sformatf("vec%0d_clk", j), tmds_clk, 10'h3E0);
            end
        end

        // Latency of a single 0xFF pixel following blanking
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF);
        for (int k = 1; k < LAT; k++) begin
            step;
            drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            chk($sformatf("lat_early%0d", k), tmds_blue, 10'h354);
        end
        step;
        chk("lat_blue_ff", tmds_blue, 10'h200);
        chk("lat_green_00", tmds_green, 10'h100);
        chk("lat_red_00", tmds_red, 10'h100);

        // Reset during active video, then refill
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step;
        step;
        step;
        reset = 1'b1;
        step;
        chk("midrst_blue", tmds_blue, 10'h354);
        chk("midrst_green", tmds_green, 10'h354);
        chk("midrst_red", tmds_red, 10'h354);
        step;
        reset = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            step;
            chk($sformatf("refill%0d_blue", k), tmds_blue, 10'h354);
        end
        step;
        chk("refill_blue", tmds_blue, 10'h100);
        chk("refill_green", tmds_green, 10'h100);
        chk("refill_red", tmds_red, 10'h100);

        // Random pixels with periodic blanking (each run opens with blanking)
        for (int k = 0; k < NR; k++) begin
            h_de[k] = (k % 20) >= 4;
            h_hs[k] = 1'($urandom_range(1, 0));
            h_vs[k] = 1'($urandom_range(1, 0));
            h_r[k]  = 8'($urandom_range(255, 0));
            h_g[k]  = 8'($urandom_range(255, 0));
            h_b[k]  = 8'($urandom_range(255, 0));
        end
        for (int c = 0; c < 3; c++) rs[c] = 0;
        for (int i = 0; i < NR + LAT - 1; i++) begin
            int j;
            if (i < NR) drive(h_de[i], h_hs[i], h_vs[i], h_r[i], h_g[i], h_b[i]);
            else drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            step;
            j = i - (LAT - 1);
            if (j >= 0) begin
                check_rand(0, tmds_blue, h_de[j], h_vs[j], h_hs[j], h_b[j]);
                check_rand(1, tmds_green, h_de[j], 1'b0, 1'b0, h_g[j]);
                check_rand(2, tmds_red, h_de[j], 1'b0, 1'b0, h_r[j]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
